// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS32 pipeline stages.
//   - itype_e  : instruction class carried from decode into execute
//   - OP_*     : primary opcode values (IR[31:26])
//   - MODE_*   : system mode encodings shared with ifetch
//   - idex_t   : ID/EX pipeline register payload; BUBBLE is its empty value
//   - op_class : maps a primary opcode to its instruction class
package mips_pkg;

   localparam logic [1:0] MODE_RUN  = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b10;

   typedef enum logic [2:0] {
      IT_RR     = 3'd0,
      IT_RM     = 3'd1,
      IT_LOAD   = 3'd2,
      IT_STORE  = 3'd3,
      IT_BRANCH = 3'd4,
      IT_JUMP   = 3'd5,
      IT_HALT   = 3'd6,
      IT_NOP    = 3'd7
   } itype_e;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] OP_HLT     = 6'h3F;

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] ir;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  rd;
      itype_e      itype;
      logic        valid;
   } idex_t;

   localparam idex_t BUBBLE = '{npc: 32'd0, ir: 32'd0, a: 32'd0, b: 32'd0,
                                imm: 32'd0, rd: 5'd0, itype: IT_NOP,
                                valid: 1'b0};

   function automatic itype_e op_class(input logic [5:0] op);
      itype_e c;
      case (op)
         OP_SPECIAL:                    c = IT_RR;
         OP_ADDI, OP_SLTI,
         OP_ANDI, OP_ORI:               c = IT_RM;
         OP_LW:                         c = IT_LOAD;
         OP_SW:                         c = IT_STORE;
         OP_BEQ, OP_BNE:                c = IT_BRANCH;
         OP_J:                          c = IT_JUMP;
         OP_HLT:                        c = IT_HALT;
         default:                       c = IT_NOP;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/regfile.sv
// regfile: general register file for the decode stage.
//   clk, rst           : clock; synchronous active-high clear of every entry
//   ra_addr / ra_data  : read port A (combinational)
//   rb_addr / rb_data  : read port B (combinational)
//   wb_en/addr/data    : single write port, committed on the rising edge
// r0 always reads zero and is never written. A read of the register being
// written this cycle returns the incoming write data (write-through).
module regfile #(
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra_addr,
   input  logic [4:0]  rb_addr,
   output logic [31:0] ra_data,
   output logic [31:0] rb_data,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data
);

   logic [31:0] regs_q [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= 32'd0;
         end
      end else if (wb_en && (wb_addr != 5'd0)) begin
         regs_q[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      ra_data = 32'd0;
      if (ra_addr != 5'd0) begin
         ra_data = (wb_en && (wb_addr == ra_addr)) ? wb_data : regs_q[ra_addr];
      end
   end

   always_comb begin
      rb_data = 32'd0;
      if (rb_addr != 5'd0) begin
         rb_data = (wb_en && (wb_addr == rb_addr)) ? wb_data : regs_q[rb_addr];
      end
   end

endmodule

// File: rtl/idecode.sv
// idecode: MIPS32 instruction-decode stage.
//   Inputs : clk, rst (sync, active-high), mode (00 = run), NPC_in/IR_in from
//            fetch, stall/flush pipeline controls, wb_en/wb_addr/wb_data from WB.
//   Outputs: ID/EX register NPC, IR, A, B, Imm, rd, itype, valid, and the
//            sticky halted flag.
// Each edge the ID/EX register takes, in priority order: reset, bubble on
// flush, hold on stall, bubble while loading or halted, else the decode.
module idecode
   import mips_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   input  logic [31:0] NPC_in,
   input  logic [31:0] IR_in,
   input  logic        stall,
   input  logic        flush,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic [31:0] NPC,
   output logic [31:0] IR,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [31:0] Imm,
   output logic [4:0]  rd,
   output logic [2:0]  itype,
   output logic        valid,
   output logic        halted
);

   typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_HALT} state_e;

   state_e      state_q, state_d;
   idex_t       idex_q, idex_d;
   idex_t       dec;
   logic [31:0] rs_val, rt_val;

   regfile #(.NREG(NREG)) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (IR_in[25:21]),
      .rb_addr (IR_in[20:16]),
      .ra_data (rs_val),
      .rb_data (rt_val),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   // Combinational decode of the instruction currently presented by fetch.
   always_comb begin
      dec       = BUBBLE;
      dec.npc   = NPC_in;
      dec.ir    = IR_in;
      dec.a     = rs_val;
      dec.b     = rt_val;
      dec.itype = op_class(IR_in[31:26]);
      dec.valid = (dec.itype != IT_NOP);
      dec.imm   = {{16{IR_in[15]}}, IR_in[15:0]};
      case (dec.itype)
         IT_RR:   dec.imm = 32'd0;
         IT_JUMP: dec.imm = {6'b0, IR_in[25:0]};
         default: begin
            // Logical immediates are zero-extended, everything else signed.
            if ((IR_in[31:26] == OP_ANDI) || (IR_in[31:26] == OP_ORI)) begin
               dec.imm = {16'd0, IR_in[15:0]};
            end
         end
      endcase
      case (dec.itype)
         IT_RR:          dec.rd = IR_in[15:11];
         IT_RM, IT_LOAD: dec.rd = IR_in[20:16];
         default:        dec.rd = 5'd0;
      endcase
   end

   // Next ID/EX contents and decode state. Reset is applied in the flop.
   always_comb begin
      idex_d  = idex_q;
      state_d = state_q;
      if (flush) begin
         idex_d = BUBBLE;
      end else if (stall) begin
         idex_d = idex_q;
      end else if (state_q == ST_HALT) begin
         idex_d = BUBBLE;
      end else if (mode != MODE_RUN) begin
         idex_d  = BUBBLE;
         state_d = ST_LOAD;
      end else begin
         idex_d  = dec;
         state_d = (dec.itype == IT_HALT) ? ST_HALT : ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q  <= BUBBLE;
         state_q <= ST_RUN;
      end else begin
         idex_q  <= idex_d;
         state_q <= state_d;
      end
   end

   assign NPC    = idex_q.npc;
   assign IR     = idex_q.ir;
   assign A      = idex_q.a;
   assign B      = idex_q.b;
   assign Imm    = idex_q.imm;
   assign rd     = idex_q.rd;
   assign itype  = idex_q.itype;
   assign valid  = idex_q.valid;
   assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_idecode.sv
// tb_idecode: randomized and directed checks of idecode against a
// behavioural model of the decode stage and its register file.
module tb_idecode;

   logic        clk = 1'b0;
   logic        rst, stall, flush, wb_en;
   logic [1:0]  mode;
   logic [31:0] npc_in, ir_in, wb_data;
   logic [4:0]  wb_addr;
   logic [31:0] NPC, IR, A, B, Imm;
   logic [4:0]  rd;
   logic [2:0]  itype;
   logic        valid, halted;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   idecode dut (
      .clk(clk), .rst(rst), .mode(mode), .NPC_in(npc_in), .IR_in(ir_in),
      .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .NPC(NPC), .IR(IR), .A(A), .B(B), .Imm(Imm),
      .rd(rd), .itype(itype), .valid(valid), .halted(halted)
   );

   // ---------------- reference model ----------------
   logic [31:0] mreg [32];
   logic [31:0] m_npc, m_ir, m_a, m_b, m_imm;
   logic [4:0]  m_rd;
   logic [2:0]  m_it;
   logic        m_valid, m_halted;

   wire [169:0] act_vec = {NPC, IR, A, B, Imm, rd, itype, valid, halted};

   function automatic logic [169:0] exp_vec();
      return {m_npc, m_ir, m_a, m_b, m_imm, m_rd, m_it, m_valid, m_halted};
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (wb_en && wb_addr == idx) return wb_data;
      return mreg[idx];
   endfunction

   task automatic set_bubble();
      m_npc = 0; m_ir = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0;
      m_it = 3'd7; m_valid = 1'b0;
   endtask

   // Advance one clock edge: update model from current inputs, then let
   // the DUT take the same edge and settle.
   task automatic clock();
      logic [5:0]  op;
      logic [31:0] sx;
      op = ir_in[31:26];
      sx = {{16{ir_in[15]}}, ir_in[15:0]};
      if (rst) begin
         set_bubble();
         m_halted = 1'b0;
         for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      end else begin
         if (flush) begin
            set_bubble();
         end else if (stall) begin
            // hold
         end else if (mode != 2'b00 || m_halted) begin
            set_bubble();
         end else begin
            m_npc = npc_in; m_ir = ir_in;
            m_a = model_read(ir_in[25:21]);
            m_b = model_read(ir_in[20:16]);
            m_valid = 1'b1; m_imm = sx; m_rd = 5'd0;
            case (op)
               6'h00: begin m_it = 0; m_rd = ir_in[15:11]; m_imm = 0; end
               6'h08, 6'h0A: begin m_it = 1; m_rd = ir_in[20:16]; end
               6'h0C, 6'h0D: begin m_it = 1; m_rd = ir_in[20:16];
                                   m_imm = {16'd0, ir_in[15:0]}; end
               6'h23: begin m_it = 2; m_rd = ir_in[20:16]; end
               6'h2B: m_it = 3;
               6'h04, 6'h05: m_it = 4;
               6'h02: begin m_it = 5; m_imm = {6'd0, ir_in[25:0]}; end
               6'h3F: begin m_it = 6; m_halted = 1'b1; end
               default: begin m_it = 7; m_valid = 1'b0; end
            endcase
         end
         if (wb_en && wb_addr != 5'd0) mreg[wb_addr] = wb_data;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; stall = 0; flush = 0; wb_en = 0; mode = 2'b00;
      wb_addr = 0; wb_data = 0; npc_in = 0; ir_in = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1; npc_in = 32'h44; ir_in = 32'h00A5_3020;
      clock(); clock();
      rst = 0;
      checks++;
      if (act_vec !== exp_vec()) begin
         errors++; $display("FAIL reset_vec got=%h exp=%h", act_vec, exp_vec());
      end
      checks++;
      if (itype !== 3'd7 || halted !== 1'b0 || valid !== 1'b0) begin
         errors++; $display("FAIL reset_itype got=%0d/%b/%b exp=7/0/0", itype, halted, valid);
      end
      $display("reset: itype=%0d valid=%b halted=%b", itype, valid, halted);
   endtask

   task automatic test_bypass();
      wb_en = 1; wb_addr = 5; wb_data = 32'h1234_5678; ir_in = 32'h0;
      clock();
      wb_en = 0; ir_in = 32'h00A5_3020; npc_in = 32'h100;
      clock();
      checks++;
      if ({A, B, rd, itype, valid} !== {32'h1234_5678, 32'h1234_5678, 5'd6, 3'd0, 1'b1}) begin
         errors++; $display("FAIL rr_decode got A=%h B=%h rd=%0d it=%0d v=%b exp A=B=12345678 rd=6 it=0 v=1",
                             A, B, rd, itype, valid);
      end
      checks++;
      if (act_vec !== exp_vec()) begin
         errors++; $display("FAIL rr_vec got=%h exp=%h", act_vec, exp_vec());
      end
      $display("rr: A=%h B=%h rd=%0d", A, B, rd);
   endtask

   task automatic test_imm();
      ir_in = 32'h2001_FFFC; clock();
      checks++;
      if ({Imm, rd, A, itype} !== {32'hFFFF_FFFC, 5'd1, 32'd0, 3'd1}) begin
         errors++; $display("FAIL addi got Imm=%h rd=%0d A=%h it=%0d exp FFFFFFFC/1/0/1", Imm, rd, A, itype);
      end
      ir_in = 32'h3401_FFFC; clock();
      checks++;
      if (Imm !== 32'h0000_FFFC) begin
         errors++; $display("FAIL ori_imm got=%h exp=0000fffc", Imm);
      end
      ir_in = 32'h0812_3456; clock();
      checks++;
      if ({Imm, itype, rd} !== {32'h0012_3456, 3'd5, 5'd0}) begin
         errors++; $display("FAIL jump got Imm=%h it=%0d rd=%0d exp 00123456/5/0", Imm, itype, rd);
      end
      $display("imm: last Imm=%h", Imm);
   endtask

   task automatic test_r0();
      logic [31:0] d;
      d = $urandom;
      wb_en = 1; wb_addr = 7; wb_data = d;
      ir_in = {6'h00, 5'd7, 5'd0, 5'd3, 11'd0};
      clock();
      checks++;
      if (A !== d) begin
         errors++; $display("FAIL bypass_r7 got=%h exp=%h", A, d);
      end
      wb_addr = 0; wb_data = 32'hDEAD_BEEF; ir_in = {6'h00, 5'd0, 5'd0, 5'd3, 11'd0};
      clock();
      wb_en = 0;
      clock();
      checks++;
      if ({A, B} !== 64'd0) begin
         errors++; $display("FAIL r0_read got A=%h B=%h exp 0", A, B);
      end
      ir_in = {6'h00, 5'd7, 5'd7, 5'd3, 11'd0}; clock();
      checks++;
      if (act_vec !== exp_vec()) begin
         errors++; $display("FAIL r7_array got=%h exp=%h", act_vec, exp_vec());
      end
      $display("r0/bypass: A=%h", A);
   endtask

   task automatic test_stall_flush();
      logic [169:0] frozen;
      ir_in = 32'h2003_0011; npc_in = 32'h200; clock();
      frozen = act_vec;
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         ir_in = $urandom; npc_in = $urandom;
         clock();
         checks++;
         if (act_vec !== frozen || act_vec !== exp_vec()) begin
            errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, act_vec, frozen);
         end
      end
      flush = 1; clock();
      checks++;
      if ({valid, itype, IR} !== {1'b0, 3'd7, 32'd0} || act_vec !== exp_vec()) begin
         errors++; $display("FAIL stall_flush got v=%b it=%0d IR=%h exp 0/7/0", valid, itype, IR);
      end
      stall = 0; flush = 0;
      $display("stall/flush: valid=%b itype=%0d", valid, itype);
   endtask

   task automatic test_mode();
      mode = 2'b10; ir_in = 32'h8C22_0004;
      clock(); clock();
      checks++;
      if ({valid, itype} !== {1'b0, 3'd7}) begin
         errors++; $display("FAIL load_mode got v=%b it=%0d exp 0/7", valid, itype);
      end
      mode = 2'b00; clock();
      checks++;
      if ({itype, rd, Imm, valid} !== {3'd2, 5'd2, 32'd4, 1'b1}) begin
         errors++; $display("FAIL lw_decode got it=%0d rd=%0d Imm=%h v=%b exp 2/2/4/1", itype, rd, Imm, valid);
      end
      $display("mode: itype=%0d rd=%0d Imm=%h", itype, rd, Imm);
   endtask

   task automatic test_halt();
      ir_in = 32'hFC00_0000; clock();
      checks++;
      if ({itype, halted} !== {3'd6, 1'b1}) begin
         errors++; $display("FAIL halt got it=%0d h=%b exp 6/1", itype, halted);
      end
      ir_in = 32'h2001_0005; clock(); clock();
      checks++;
      if ({valid, itype, halted} !== {1'b0, 3'd7, 1'b1}) begin
         errors++; $display("FAIL halt_bubble got v=%b it=%0d h=%b exp 0/7/1", valid, itype, halted);
      end
      rst = 1; clock(); rst = 0;
      checks++;
      if (halted !== 1'b0 || act_vec !== exp_vec()) begin
         errors++; $display("FAIL halt_reset got h=%b exp 0", halted);
      end
      $display("halt: halted=%b after reset", halted);
   endtask

   task automatic test_random();
      logic [5:0] ops [12];
      ops = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h11};
      for (int n = 0; n < 400; n++) begin
         int k;
         k = $urandom_range(0, 10) == 0 ? 10 + $urandom_range(0, 1) : $urandom_range(0, 9);
         if (k == 10 && $urandom_range(0, 3) != 0) k = 0;
         rst     = ($urandom_range(0, 39) == 0);
         stall   = ($urandom_range(0, 7) == 0);
         flush   = ($urandom_range(0, 9) == 0);
         mode    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         wb_en   = $urandom_range(0, 1);
         wb_addr = 5'($urandom_range(0, 7));
         wb_data = $urandom;
         npc_in  = $urandom;
         ir_in   = {ops[k], 26'($urandom)};
         if ($urandom_range(0, 1) == 1) ir_in[25:16] = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         clock();
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL random[%0d] got=%h exp=%h", n, act_vec, exp_vec());
         end
         $display("rand %0d: ir=%h it=%0d v=%b h=%b", n, ir_in, itype, valid, halted);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      set_bubble();
      m_halted = 1'b0;
      test_reset();
      test_bypass();
      test_imm();
      test_r0();
      test_stall_flush();
      test_mode();
      test_halt();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/idecode.md
# idecode

Instruction-decode stage of the MIPS32 pipeline, directly downstream of `ifetch`. It consumes `IR`/`NPC` from fetch, owns the 32×32 general register file, and classifies the instruction. It reads operands, forms the immediate, and registers everything into the ID/EX pipeline register for the execute stage. It also accepts the writeback port from WB and tracks the sticky halt condition.

## Interface
- `NREG`, 32: register-file depth (fixed; r0 hardwired zero)
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, synchronous, active-high
- `mode` in 2: system mode shared with `ifetch`; `2'b00` = run, any other value = program-load/idle
- `NPC_in` in 32: next PC from `ifetch.NPC`
- `IR_in` in 32: instruction from `ifetch.IR`
- `stall` in 1: hold ID/EX register contents
- `flush` in 1: replace the next ID/EX contents with a bubble (branch taken)
- `wb_en` in 1: register-file write enable from WB
- `wb_addr` in 5: write register index
- `wb_data` in 32: write data
- `NPC` out 32, `IR` out 32: registered pass-through
- `A` out 32, `B` out 32: registered rs / rt operand values
- `Imm` out 32: registered extended immediate
- `rd` out 5: destination register index (0 = no write)
- `itype` out 3: instruction class
- `valid` out 1: ID/EX holds a real instruction
- `halted` out 1: sticky, set once HLT is issued

## Operation
- Opcode `IR_in[31:26]` maps to `itype`:
  - `0x00` → RR_ALU(0)
  - `0x08`/`0x0A`/`0x0C`/`0x0D` → RM_ALU(1)
  - `0x23` → LOAD(2)
  - `0x2B` → STORE(3)
  - `0x04`/`0x05` → BRANCH(4)
  - `0x02` → JUMP(5)
  - `0x3F` → HALT(6)
  - any other opcode → NOP(7) with `valid=0`
- `Imm` rules:
  - sign-extend `IR_in[15:0]` by default
  - zero-extend for `0x0C`/`0x0D`
  - JUMP: `{6'b0, IR_in[25:0]}`
  - RR_ALU: 0
- `rd` rules:
  - RR_ALU: `IR_in[15:11]`
  - RM_ALU and LOAD: `IR_in[20:16]`
  - all other classes: 0
- Operand read: A = reg[`IR_in[25:21]`], B = reg[`IR_in[20:16]`], both combinational reads.
  - Index 0 always reads 0.
  - Write-through bypass: if `wb_en` and `wb_addr`==index and index≠0, the read returns `wb_data`.
- Register file:
  - written at the clock edge when `wb_en` and `wb_addr`≠0; writes to r0 are ignored.
  - writes occur regardless of stall, flush, mode or halted.
- Bubble: `valid=0`, `itype=7`, and `IR`, `NPC`, `A`, `B`, `Imm`, `rd` all 0.
- ID/EX update priority per edge, highest first:
  1. `rst`: all outputs 0 except `itype=7`; `halted=0`; all register-file entries cleared to 0.
  2. `flush`: load a bubble. `halted` is unchanged.
  3. `stall`: hold all outputs.
  4. `mode`≠`2'b00` or `halted`=1: load a bubble.
  5. Otherwise: load the decoded instruction with `valid=1` (except for unknown opcodes, which give `valid=0`).
- `halted` is set on the edge that loads a HALT instruction (case 5). It clears only on `rst`.
- Decode states: RUN (normal), LOAD (`mode`≠0, bubbles), HALT (`halted`=1, bubbles). Transitions follow the priority list; HALT is exited only through `rst`.

## Timing
- Latency is 1 cycle: `IR_in` sampled at edge N appears on outputs after edge N.
- A WB write at edge N is visible to decode in cycle N through the bypass, and from the array from cycle N+1.
- `flush` and `stall` together: flush wins.
- `rst` mid-stall or mid-halt: everything returns to reset values on the next edge.
- `mode` returning to `2'b00`: the first real instruction is decoded on that same edge.

## Structure
- Shared package `mips_pkg`:
  - `itype` encodings (`IT_RR`..`IT_NOP`)
  - opcode localparams
  - `BUBBLE` constants
  - mode encodings (`MODE_RUN=2'b00`, `MODE_LOAD=2'b10`)
- Sub-module `regfile`: 32×32 array, two read ports with write-through bypass, one write port, synchronous clear on `rst`, r0 forced to 0.

## Test plan
- Reset, then `wb_en=1, wb_addr=5, wb_data=32'h1234_5678`; next cycle `IR_in=32'h00A5_3020` (rs=5, rt=5, rd=6) → `A=B=32'h1234_5678`, `rd=6`, `itype=0`, `valid=1`.
- `IR_in=32'h2001_FFFC` (ADDI r1,r0,-4) → `Imm=32'hFFFF_FFFC`, `rd=1`, `A=0`. `IR_in=32'h3401_FFFC` (ORI) → `Imm=32'h0000_FFFC`.
- Write r7 and present an instruction reading r7 in the same cycle → `A` equals the new `wb_data`. Write to r0 → subsequent reads of r0 return 0.
- `stall=1` for 3 cycles while `IR_in` changes → outputs frozen. `stall=1` with `flush=1` → bubble (`valid=0`, `itype=7`, `IR=0`).
- `mode=2'b10` with `IR_in=32'h8C22_0004` → bubbles. `mode=2'b00` → LW decoded: `itype=2`, `rd=2`, `Imm=4`.
- `IR_in=32'hFC00_0000` → next cycle `itype=6`, `halted=1`. Later valid instructions → bubbles. `rst` → `halted=0`.
